if_fetch: RTL and testbench

IF_FETCH -- requirements
Module: if_fetch

---
 rtl/cpu_pkg.sv | 21 ++
 rtl/if_pc_reg.sv | 53 +++++
 rtl/if_fetch.sv | 135 +++++++++++++
 tb/tb_if_fetch.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// ============================================================================
// cpu_pkg -- shared fetch-stage types and constants
// Rev 1.0
// ============================================================================
`default_nettype none

package cpu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_WAIT  = 2'd2
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [31:0] PC_STEP_DEF  = 32'd4;
    localparam logic [31:0] NOP          = 32'h0000_0000;

endpackage

`default_nettype wire

// File: rtl/if_pc_reg.sv
// ============================================================================
// if_pc_reg -- program counter with redirect/step/hold next-PC priority mux
// Rev 1.0
// ============================================================================
`default_nettype none

module if_pc_reg
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter logic [31:0] PC_STEP  = PC_STEP_DEF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        advance_i,
    input  logic        pending_i,
    input  logic [31:0] pending_target_i,
    input  logic        branch_taken_i,
    input  logic [31:0] branch_target_i,
    input  logic        pc_write_i,
    output logic [31:0] pc_o
);

    logic [31:0] pc_q;
    logic [31:0] pc_d;

    // A redirect latched during a miss outranks anything ID presents on the ack cycle.
    always_comb begin
        pc_d = pc_q;
        if (advance_i) begin
            if (pending_i) begin
                pc_d = pending_target_i;
            end else if (branch_taken_i) begin
                pc_d = branch_target_i;
            end else if (pc_write_i) begin
                pc_d = pc_q + PC_STEP;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

`default_nettype wire

// File: rtl/if_fetch.sv
// ============================================================================
// if_fetch -- fetch FSM and I-cache handshake; IF_FETCH_PERF_EN adds counters
// Rev 1.0
// ============================================================================
`default_nettype none

module if_fetch
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter logic [31:0] PC_STEP  = PC_STEP_DEF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        pc_write_i,
    input  logic        branch_taken_i,
    input  logic [31:0] branch_target_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,
`ifdef IF_FETCH_PERF_EN
    output logic [31:0] fetch_cnt_o,
    output logic [31:0] stall_cnt_o,
`endif
    output logic [31:0] pc_o,
    output logic [31:0] instr_o,
    output logic        instr_valid_o,
    output logic        flush_o,
    output logic        stall_o
);

    fetch_state_e state_q, state_d;
    logic         pending_q, pending_d;
    logic [31:0]  pend_target_q, pend_target_d;
    logic         advance;

    always_comb begin
        state_d       = state_q;
        pending_d     = pending_q;
        pend_target_d = pend_target_q;
        mem_req_o     = 1'b0;
        instr_o       = NOP;
        instr_valid_o = 1'b0;
        flush_o       = 1'b0;
        stall_o       = 1'b1;
        advance       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
            end
            ST_FETCH, ST_WAIT: begin
                mem_req_o = 1'b1;
                if (mem_ack_i) begin
                    stall_o = 1'b0;
                    advance = 1'b1;
                    state_d = ST_FETCH;
                    // The returned word belongs to the wrong path once a redirect is pending.
                    if (pending_q) begin
                        flush_o   = 1'b1;
                        pending_d = 1'b0;
                    end else begin
                        instr_o       = mem_rdata_i;
                        instr_valid_o = 1'b1;
                        flush_o       = branch_taken_i;
                    end
                end else begin
                    state_d = ST_WAIT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (stall_o && branch_taken_i) begin
            pending_d     = 1'b1;
            pend_target_d = branch_target_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= ST_IDLE;
            pending_q     <= 1'b0;
            pend_target_q <= RESET_PC;
        end else begin
            state_q       <= state_d;
            pending_q     <= pending_d;
            pend_target_q <= pend_target_d;
        end
    end

    if_pc_reg #(
        .RESET_PC (RESET_PC),
        .PC_STEP  (PC_STEP)
    ) u_pc_reg (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .advance_i        (advance),
        .pending_i        (pending_q),
        .pending_target_i (pend_target_q),
        .branch_taken_i   (branch_taken_i),
        .branch_target_i  (branch_target_i),
        .pc_write_i       (pc_write_i),
        .pc_o             (pc_o)
    );

    assign mem_addr_o = pc_o;

`ifdef IF_FETCH_PERF_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        fetch_cnt_d = fetch_cnt_q + {31'd0, instr_valid_o};
        stall_cnt_d = stall_cnt_q + {31'd0, stall_o};
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fetch_cnt_q <= 32'd0;
            stall_cnt_q <= 32'd0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign fetch_cnt_o = fetch_cnt_q;
    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_if_fetch.sv
// ============================================================================
// tb_if_fetch -- directed vector bench for if_fetch
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_if_fetch;

    logic        clk;
    logic        rst;
    logic        pc_write;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        instr_valid;
    logic        flush;
    logic        stall;
`ifdef IF_FETCH_PERF_EN
    logic [31:0] fetch_cnt;
    logic [31:0] stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    if_fetch dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .pc_write_i      (pc_write),
        .branch_taken_i  (branch_taken),
        .branch_target_i (branch_target),
        .mem_req_o       (mem_req),
        .mem_addr_o      (mem_addr),
        .mem_ack_i       (mem_ack),
        .mem_rdata_i     (mem_rdata),
`ifdef IF_FETCH_PERF_EN
        .fetch_cnt_o     (fetch_cnt),
        .stall_cnt_o     (stall_cnt),
`endif
        .pc_o            (pc),
        .instr_o         (instr),
        .instr_valid_o   (instr_valid),
        .flush_o         (flush),
        .stall_o         (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ack;
        logic        br;
        logic [31:0] tgt;
        logic        pcw;
        logic [31:0] rdata;
        logic [31:0] e_pc;
        logic        e_req;
        logic        e_valid;
        logic        e_stall;
        logic        e_flush;
    } vec_t;

    localparam int NVEC = 20;
    vec_t vecs [NVEC];

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        //          ack  br  tgt           pcw  rdata          pc            req  val  stl  fls
        vecs[0]  = '{1'b1, 1'b0, 32'h0,        1'b1, 32'hDEAD_0000, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 32'h0,        1'b1, 32'hA000_0000, 32'h0,        1'b1, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 32'h0,        1'b1, 32'hA000_0001, 32'h4,        1'b1, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 32'h0,        1'b1, 32'hA000_0002, 32'h8,        1'b1, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 32'h0,        1'b1, 32'hA000_0003, 32'hC,        1'b1, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 32'h0,        1'b0, 32'hA000_0004, 32'h10,       1'b1, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 32'h0,        1'b0, 32'hA000_0005, 32'h10,       1'b1, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 32'h0,        1'b0, 32'hBAD0_0000, 32'h10,       1'b1, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 32'h0,        1'b0, 32'hBAD0_0001, 32'h10,       1'b1, 1'b0, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 32'h0,        1'b1, 32'hBAD0_0002, 32'h10,       1'b1, 1'b0, 1'b1, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 32'h0,        1'b1, 32'hA000_0006, 32'h10,       1'b1, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 1'b1, 32'h40,       1'b1, 32'hA000_0007, 32'h14,       1'b1, 1'b1, 1'b0, 1'b1};
        vecs[12] = '{1'b0, 1'b0, 32'h0,        1'b1, 32'hBAD0_0003, 32'h40,       1'b1, 1'b0, 1'b1, 1'b0};
        vecs[13] = '{1'b0, 1'b1, 32'h70,       1'b1, 32'hBAD0_0004, 32'h40,       1'b1, 1'b0, 1'b1, 1'b0};
        vecs[14] = '{1'b0, 1'b1, 32'h80,       1'b1, 32'hBAD0_0005, 32'h40,       1'b1, 1'b0, 1'b1, 1'b0};
        vecs[15] = '{1'b1, 1'b0, 32'h0,        1'b1, 32'hA000_0008, 32'h40,       1'b1, 1'b0, 1'b0, 1'b1};
        vecs[16] = '{1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1, 32'hA000_0009, 32'h80,      1'b1, 1'b1, 1'b0, 1'b1};
        vecs[17] = '{1'b1, 1'b0, 32'h0,        1'b1, 32'hA000_000A, 32'hFFFF_FFFC, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[18] = '{1'b1, 1'b0, 32'h0,        1'b1, 32'hA000_000B, 32'h0,        1'b1, 1'b1, 1'b0, 1'b0};
        vecs[19] = '{1'b0, 1'b0, 32'h0,        1'b1, 32'hBAD0_0006, 32'h4,        1'b1, 1'b0, 1'b1, 1'b0};

        rst           = 1'b1;
        pc_write      = 1'b1;
        branch_taken  = 1'b0;
        branch_target = 32'h0;
        mem_ack       = 1'b0;
        mem_rdata     = 32'h0;

        @(negedge clk);
        #1;
        chk32("rst pc", pc, 32'h0);
        chk1("rst req", mem_req, 1'b0);
        chk1("rst valid", instr_valid, 1'b0);
        chk1("rst flush", flush, 1'b0);
        chk32("rst instr", instr, 32'h0);

        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            if (i == 0) rst = 1'b0;
            mem_ack       = vecs[i].ack;
            branch_taken  = vecs[i].br;
            branch_target = vecs[i].tgt;
            pc_write      = vecs[i].pcw;
            mem_rdata     = vecs[i].rdata;
            #1;
            chk32($sformatf("v%0d pc", i), pc, vecs[i].e_pc);
            chk1($sformatf("v%0d req", i), mem_req, vecs[i].e_req);
            chk1($sformatf("v%0d valid", i), instr_valid, vecs[i].e_valid);
            chk1($sformatf("v%0d stall", i), stall, vecs[i].e_stall);
            chk1($sformatf("v%0d flush", i), flush, vecs[i].e_flush);
            if (vecs[i].e_req) chk32($sformatf("v%0d addr", i), mem_addr, vecs[i].e_pc);
            if (vecs[i].e_valid) chk32($sformatf("v%0d instr", i), instr, vecs[i].rdata);
        end

        // Reset pulse while waiting on a miss at pc=4; the ack then lands in IDLE.
        @(negedge clk);
        mem_ack      = 1'b0;
        branch_taken = 1'b0;
        rst          = 1'b1;
        #1;
        chk32("midrst pc", pc, 32'h0);
        chk1("midrst req", mem_req, 1'b0);
        chk1("midrst valid", instr_valid, 1'b0);
        chk1("midrst flush", flush, 1'b0);
        chk32("midrst instr", instr, 32'h0);
`ifdef IF_FETCH_PERF_EN
        chk32("midrst fetch_cnt", fetch_cnt, 32'h0);
        chk32("midrst stall_cnt", stall_cnt, 32'h0);
`endif

        @(negedge clk);
        rst       = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        pc_write  = 1'b1;
        #1;
        chk1("late ack req", mem_req, 1'b0);
        chk1("late ack valid", instr_valid, 1'b0);
        chk1("late ack stall", stall, 1'b1);
        chk32("late ack pc", pc, 32'h0);

        @(negedge clk);
        mem_ack = 1'b0;
        #1;
        chk1("post idle req", mem_req, 1'b1);
        chk1("post idle stall", stall, 1'b1);
        chk32("post idle pc", pc, 32'h0);
        chk32("post idle addr", mem_addr, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
